// File: rtl/uart_cmd_parser.sv
// Frame parser behind the UART receiver: [SOF][ADDR][LEN][DATA..][CSUM] frames are
// buffered and replayed as register-write strobes only after the checksum matches.
module uart_cmd_parser #(
  parameter int         CLK_FREQ      = 100_000_000,
  parameter int         UART_BPS      = 115_200,
  parameter int         TIMEOUT_BYTES = 4,
  parameter int         MAX_LEN       = 16,
  parameter logic [7:0] SOF           = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int BYTE_CYC    = 10 * (CLK_FREQ / UART_BPS);
  localparam int TIMEOUT_CYC = TIMEOUT_BYTES * BYTE_CYC;
  localparam int TW          = $clog2(TIMEOUT_CYC);
  localparam int IW          = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  // Fire on the edge where the counter would reach TIMEOUT_CYC-1, so frame_err
  // lands exactly TIMEOUT_CYC cycles after the last accepted byte.
  localparam logic [TW-1:0] TO_FIRE  = TW'(TIMEOUT_CYC - 2);
  localparam logic [7:0]    MAX_LEN8 = 8'(MAX_LEN);

  localparam logic [1:0] ERR_CSUM = 2'b01;
  localparam logic [1:0] ERR_TO   = 2'b10;
  localparam logic [1:0] ERR_LEN  = 2'b11;

  typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, CSUM, COMMIT} state_t;

  state_t          state;
  logic [7:0]      base;
  logic [7:0]      len;
  logic [7:0]      csum;
  logic [7:0]      idx;
  logic [TW-1:0]   tcnt;
  logic [7:0]      pbuf [MAX_LEN];

  // Payload storage needs no reset; idx is always below len <= MAX_LEN here.
  always_ff @(posedge clk) begin
    if (state == DATA && rx_done)
      pbuf[idx[IW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      base      <= '0;
      len       <= '0;
      csum      <= '0;
      idx       <= '0;
      tcnt      <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= '0;
      busy      <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (rx_done && rx_data == SOF) begin
            state <= ADDR;
            busy  <= 1'b1;
          end
        end

        ADDR, LEN, DATA, CSUM: begin
          if (rx_done) begin
            tcnt <= '0;
            case (state)
              ADDR: begin
                base  <= rx_data;
                csum  <= rx_data;
                state <= LEN;
              end
              LEN: begin
                if (rx_data == 8'd0 || rx_data > MAX_LEN8) begin
                  frame_err <= 1'b1;
                  err_code  <= ERR_LEN;
                  state     <= IDLE;
                  busy      <= 1'b0;
                end else begin
                  len   <= rx_data;
                  csum  <= csum + rx_data;
                  idx   <= '0;
                  state <= DATA;
                end
              end
              DATA: begin
                csum <= csum + rx_data;
                idx  <= idx + 8'd1;
                if (idx == len - 8'd1)
                  state <= CSUM;
              end
              default: begin
                if (rx_data == csum) begin
                  // First write goes out with the COMMIT entry itself.
                  state   <= COMMIT;
                  wr_en   <= 1'b1;
                  wr_addr <= base;
                  wr_data <= pbuf[0];
                  idx     <= 8'd1;
                end else begin
                  frame_err <= 1'b1;
                  err_code  <= ERR_CSUM;
                  state     <= IDLE;
                  busy      <= 1'b0;
                end
              end
            endcase
          end else if (tcnt == TO_FIRE) begin
            tcnt      <= '0;
            frame_err <= 1'b1;
            err_code  <= ERR_TO;
            state     <= IDLE;
            busy      <= 1'b0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end

        COMMIT: begin
          tcnt <= '0;
          if (idx < len) begin
            wr_en   <= 1'b1;
            wr_addr <= base + idx;
            wr_data <= pbuf[idx[IW-1:0]];
            idx     <= idx + 8'd1;
          end else begin
            frame_ok <= 1'b1;
            idx      <= '0;
            state    <= IDLE;
            busy     <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: hand-computed frames, write/pulse timing and error codes.
module tb_uart_cmd_parser;

  localparam int TC = 400; // 4 bytes * 10 * (1 MHz / 100 kBd)

  typedef logic [7:0] byte_q_t [$];

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  uart_cmd_parser #(
    .CLK_FREQ(1_000_000), .UART_BPS(100_000), .TIMEOUT_BYTES(4), .MAX_LEN(16), .SOF(8'hA5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_done(rx_done), .rx_data(rx_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ok_cnt = 0;
  int ok_cyc = -1;
  int err_cnt = 0;
  int rx_cyc = 0;
  logic [7:0] wq_addr [$];
  logic [7:0] wq_data [$];
  int         wq_cyc  [$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (wr_en) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
      wq_cyc.push_back(cyc);
    end
    if (frame_ok) begin
      ok_cnt++;
      ok_cyc = cyc;
    end
    if (frame_err) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge of the cycle after the strobe.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_done = 1'b1;
    rx_data = b;
    rx_cyc  = cyc + 1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_frame(input byte_q_t f);
    foreach (f[i]) send_byte(f[i]);
  endtask

  // Writes expected from cycle c onward, one per cycle, then frame_ok right after.
  task automatic chk_writes(input string tag, input int b, input logic [7:0] a0,
                            input byte_q_t d, input int c, input int eb);
    logic [7:0] ea;
    check({tag, "_nwr"}, wq_addr.size() - b, d.size());
    foreach (d[i]) begin
      if (b + i < wq_addr.size()) begin
        ea = a0 + 8'(i);
        check({tag, "_addr"}, wq_addr[b+i], ea);
        check({tag, "_data"}, wq_data[b+i], d[i]);
        check({tag, "_cyc"}, wq_cyc[b+i], c + i);
      end
    end
    check({tag, "_ok_cyc"}, ok_cyc, c + d.size());
    check({tag, "_no_err"}, err_cnt, eb);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, c, eb, n;
    byte_q_t f, d;

    wait_cyc(3);
    check("reset_outputs", {wr_en, wr_addr, wr_data, frame_ok, frame_err, err_code, busy}, 0);
    rst_n = 1'b1;
    wait_cyc(2);

    // good frame
    b = wq_addr.size(); eb = err_cnt;
    send_byte(8'hA5);
    check("sof_busy", busy, 1);
    f = '{8'h10, 8'h02, 8'h11, 8'h22, 8'h45};
    send_frame(f);
    c = rx_cyc;
    wait_cyc(6);
    d = '{8'h11, 8'h22};
    chk_writes("good", b, 8'h10, d, c, eb);
    check("good_code", err_code, 2'b00);
    check("good_ok_cnt", ok_cnt, 1);

    // bad checksum
    b = wq_addr.size(); eb = err_cnt;
    f = '{8'hA5, 8'h10, 8'h02, 8'h11, 8'h22, 8'h46};
    send_frame(f);
    check("csum_err", frame_err, 1);
    check("csum_code", err_code, 2'b01);
    check("csum_busy", busy, 0);
    wait_cyc(6);
    check("csum_nwr", wq_addr.size() - b, 0);
    check("csum_err_cnt", err_cnt - eb, 1);
    check("csum_ok_cnt", ok_cnt, 1);

    // timeout after the address byte
    f = '{8'hA5, 8'h10};
    send_frame(f);
    n = 1;
    while (!frame_err && n < 2 * TC) begin
      @(negedge clk);
      n++;
    end
    check("to_cycles", n, TC);
    check("to_code", err_code, 2'b10);
    wait_cyc(3);
    b = wq_addr.size(); eb = err_cnt;
    f = '{8'hA5, 8'h20, 8'h01, 8'h5A, 8'h7B};
    send_frame(f);
    c = rx_cyc;
    wait_cyc(5);
    d = '{8'h5A};
    chk_writes("after_to", b, 8'h20, d, c, eb);

    // byte arriving in the very cycle the timeout would fire wins
    b = wq_addr.size(); eb = err_cnt;
    send_byte(8'hA5);
    wait_cyc(TC - 3);
    f = '{8'h31, 8'h01, 8'h0C, 8'h3E};
    send_frame(f);
    c = rx_cyc;
    wait_cyc(5);
    d = '{8'h0C};
    chk_writes("to_edge", b, 8'h31, d, c, eb);

    // bad lengths 0 and 17, trailing junk ignored
    eb = err_cnt;
    f = '{8'hA5, 8'h10, 8'h00};
    send_frame(f);
    check("len0_err", frame_err, 1);
    check("len0_code", err_code, 2'b11);
    f = '{8'h11, 8'h22};
    send_frame(f);
    wait_cyc(3);
    check("len0_trail_busy", busy, 0);
    check("len0_err_cnt", err_cnt - eb, 1);
    f = '{8'hA5, 8'h10, 8'h11};
    send_frame(f);
    check("len17_err", frame_err, 1);
    check("len17_code", err_code, 2'b11);
    wait_cyc(3);

    // address wrap; checksum FF+02+AA+BB = 0x266 -> 66
    b = wq_addr.size(); eb = err_cnt;
    f = '{8'hA5, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'h66};
    send_frame(f);
    c = rx_cyc;
    wait_cyc(6);
    d = '{8'hAA, 8'hBB};
    chk_writes("wrap", b, 8'hFF, d, c, eb);
    f = '{8'hA5, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'h67};
    send_frame(f);
    check("wrap67_err", frame_err, 1);
    check("wrap67_code", err_code, 2'b01);
    wait_cyc(3);

    // noise then a good frame
    f = '{8'h00, 8'hFF};
    send_frame(f);
    check("noise_busy", busy, 0);
    b = wq_addr.size(); eb = err_cnt;
    f = '{8'hA5, 8'h30, 8'h01, 8'h01, 8'h32};
    send_frame(f);
    c = rx_cyc;
    wait_cyc(5);
    d = '{8'h01};
    chk_writes("noise", b, 8'h30, d, c, eb);

    // SOF value inside the payload is plain data
    b = wq_addr.size(); eb = err_cnt;
    f = '{8'hA5, 8'h60, 8'h01, 8'hA5, 8'h06};
    send_frame(f);
    c = rx_cyc;
    wait_cyc(5);
    d = '{8'hA5};
    chk_writes("sof_data", b, 8'h60, d, c, eb);

    // maximum length 16; checksum 50+10+(1..16) = E8
    b = wq_addr.size(); eb = err_cnt;
    f = '{8'hA5, 8'h50, 8'h10};
    d = '{};
    for (int i = 1; i <= 16; i++) begin
      f.push_back(8'(i));
      d.push_back(8'(i));
    end
    f.push_back(8'hE8);
    send_frame(f);
    c = rx_cyc;
    wait_cyc(20);
    chk_writes("maxlen", b, 8'h50, d, c, eb);

    // reset in the middle of DATA
    b = wq_addr.size(); eb = err_cnt;
    f = '{8'hA5, 8'h40, 8'h03, 8'h01, 8'h02};
    send_frame(f);
    rst_n = 1'b0;
    wait_cyc(1);
    check("rst_mid_outputs", {wr_en, wr_addr, wr_data, frame_ok, frame_err, err_code, busy}, 0);
    wait_cyc(1);
    rst_n = 1'b1;
    wait_cyc(3);
    check("rst_mid_nwr", wq_addr.size() - b, 0);
    check("rst_mid_err", err_cnt, eb);
    f = '{8'hA5, 8'h41, 8'h01, 8'h07, 8'h49};
    send_frame(f);
    c = rx_cyc;
    wait_cyc(5);
    d = '{8'h07};
    chk_writes("after_rst", b, 8'h41, d, c, eb);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
